// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: command sequencer for a master-slave JK flip-flop stage.
// Buffers hold/reset/set/toggle commands in a FIFO, drives J/K for rep+1
// cycles, then checks the flip-flop's Q against a predicted value.
module jk_cmd_seq #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [CNT_W-1:0]          cmd_rep,
   output logic                      J,
   output logic                      K,
   input  logic                      q_fb,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [$clog2(DEPTH):0]    fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = CNT_W + 2;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

   // FIFO storage and bookkeeping
   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             push, pop;
   logic [EW-1:0]    rd_data;
   logic [1:0]       rd_op;
   logic [CNT_W-1:0] rd_rep;

   // Sequencer state
   state_e           state_q, state_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [1:0]       op_q, op_d;
   logic             rep_lsb_q, rep_lsb_d;
   logic             j_q, j_d, k_q, k_d;
   logic             q_exp_q, q_exp_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             q_pred;

   assign cmd_ready  = (count_q != FULL);
   assign push       = cmd_valid && cmd_ready;
   assign rd_data    = mem_q[rd_ptr_q];
   assign rd_op      = rd_data[EW-1:CNT_W];
   assign rd_rep     = rd_data[CNT_W-1:0];

   assign J          = j_q;
   assign K          = k_q;
   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign err        = err_q;
   assign fifo_count = count_q;

   // Store accepted commands; storage needs no reset since count gates reads
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_op, cmd_rep};
      end
   end

   // Occupancy update: simultaneous push and pop leaves the count unchanged
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and count; pointers wrap naturally modulo DEPTH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Predicted Q after the command's drive phase; toggle flips on odd rep+1
   always_comb begin
      q_pred = q_exp_q;
      unique case (op_q)
         2'b00: q_pred = q_exp_q;
         2'b01: q_pred = 1'b0;
         2'b10: q_pred = 1'b1;
         2'b11: q_pred = q_exp_q ^ ~rep_lsb_q;
         default: q_pred = q_exp_q;
      endcase
   end

   // Sequencer next-state: pop in IDLE, count down in DRIVE, compare in CHECK
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      op_d      = op_q;
      rep_lsb_d = rep_lsb_q;
      j_d       = j_q;
      k_d       = k_q;
      q_exp_d   = q_exp_q;
      err_d     = err_q;
      done_d    = 1'b0;
      pop       = 1'b0;
      case (state_q)
         StIdle: begin
            j_d = 1'b0;
            k_d = 1'b0;
            if (count_q != '0) begin
               pop       = 1'b1;
               op_d      = rd_op;
               rep_lsb_d = rd_rep[0];
               rep_cnt_d = rd_rep;
               j_d       = rd_op[1];
               k_d       = rd_op[0];
               state_d   = StDrive;
            end
         end
         StDrive: begin
            if (rep_cnt_q == '0) begin
               j_d     = 1'b0;
               k_d     = 1'b0;
               state_d = StCheck;
            end else begin
               rep_cnt_d = rep_cnt_q - 1'b1;
            end
         end
         StCheck: begin
            if (q_pred != q_fb) err_d = 1'b1;
            // Resync so one mismatch does not cascade into later checks
            q_exp_d = q_fb;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            j_d     = 1'b0;
            k_d     = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // Sequencer state register; reset mirrors the flip-flop's own reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         rep_cnt_q <= '0;
         op_q      <= 2'b00;
         rep_lsb_q <= 1'b0;
         j_q       <= 1'b0;
         k_q       <= 1'b0;
         q_exp_q   <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rep_cnt_q <= rep_cnt_d;
         op_q      <= op_d;
         rep_lsb_q <= rep_lsb_d;
         j_q       <= j_d;
         k_q       <= k_d;
         q_exp_q   <= q_exp_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Scoreboard bench for jk_cmd_seq with a behavioural JK flip-flop on q_fb.
module tb_jk_cmd_seq;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;

   logic             clk, reset;
   logic             cmd_valid, cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_rep;
   logic             J, K, q_fb, busy, done, err;
   logic [2:0]       fifo_count;

   logic ff_q;
   logic ovr, ovr_val;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0] jk;
      int         drive_len;
      int         busy_len;
      logic       err;
      logic       q;
   } exp_t;

   exp_t exp_q[$];

   // Abstract model: flip-flop value, predicted Q, sticky error
   logic m_ff, m_qexp, m_err;

   jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_rep    (cmd_rep),
      .J          (J),
      .K          (K),
      .q_fb       (q_fb),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .fifo_count (fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream JK flip-flop
   always @(posedge clk or posedge reset) begin
      if (reset) ff_q <= 1'b0;
      else begin
         case ({J, K})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end

   assign q_fb = ovr ? ovr_val : ff_q;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model one command's whole effect at acceptance time
   task automatic model_push(input logic [1:0] op, input int rep);
      int   n;
      logic pred, seen;
      exp_t e;
      n = rep + 1;
      case (op)
         2'd0: begin pred = m_qexp; end
         2'd1: begin pred = 1'b0; m_ff = 1'b0; end
         2'd2: begin pred = 1'b1; m_ff = 1'b1; end
         default: begin
            pred = m_qexp ^ logic'(n % 2);
            m_ff = m_ff ^ logic'(n % 2);
         end
      endcase
      seen = ovr ? ovr_val : m_ff;
      if (pred != seen) m_err = 1'b1;
      m_qexp      = seen;
      e.jk        = op;
      e.drive_len = (op == 2'd0) ? n + 1 : n;
      e.busy_len  = n + 1;
      e.err       = m_err;
      e.q         = seen;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ff   = 1'b0;
      m_qexp = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic push(input logic [1:0] op, input int rep);
      int w = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_rep   = CNT_W'(rep);
      while (!cmd_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         check("push_timeout", 0, 1);
         cmd_valid = 1'b0;
      end else begin
         model_push(op, rep);
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         // Scramble payload: only the pushed values may matter
         cmd_op    = 2'($urandom);
         cmd_rep   = CNT_W'($urandom);
      end
   endtask

   task automatic wait_busy();
      int w = 0;
      while (!busy && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!busy) check("busy_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int w = 0;
      while ((busy || fifo_count != 0 || exp_q.size() != 0) && w < 600) begin
         @(negedge clk);
         w++;
      end
      if (w >= 600) check("drain_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: measure each command's busy window and score it at done
   initial begin
      logic [1:0] start_jk;
      int         blen, dlen;
      logic       in_cmd;
      exp_t       e;
      in_cmd = 1'b0;
      blen = 0;
      dlen = 0;
      start_jk = 2'b00;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_cmd = 1'b0;
         end else begin
            if (busy && !in_cmd) begin
               in_cmd   = 1'b1;
               start_jk = {J, K};
               blen     = 0;
               dlen     = 0;
            end
            if (busy) begin
               blen++;
               if ({J, K} == start_jk) dlen++;
            end
            if (done) begin
               in_cmd = 1'b0;
               if (exp_q.size() == 0) begin
                  check("done_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("jk_value", int'(start_jk), int'(e.jk));
                  check("drive_len", dlen, e.drive_len);
                  check("busy_len", blen, e.busy_len);
                  check("err_at_done", int'(err), int'(e.err));
                  check("q_at_done", int'(q_fb), int'(e.q));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_rep   = '0;
      ovr       = 1'b0;
      ovr_val   = 1'b0;
      model_reset();
      reset     = 1'b0;
      #2 reset  = 1'b1;
      #10 reset = 1'b0;
      @(negedge clk);
      // {J,K,busy,done,err,fifo_count,cmd_ready}
      check("reset_state", int'({J, K, busy, done, err, fifo_count, cmd_ready}), 1);

      // Set for one cycle, then toggle three times from Q=1
      push(2'd2, 0);
      wait_idle();
      push(2'd3, 2);
      wait_idle();

      // Fill FIFO behind a long command; sixth push must stall until a pop
      push(2'd0, 15);
      wait_busy();
      push(2'd0, 1);
      push(2'd1, 3);
      push(2'd2, 2);
      push(2'd3, 1);
      @(negedge clk);
      check("full_count", int'(fifo_count), 4);
      check("full_ready", int'(cmd_ready), 0);
      push(2'd3, 2);
      wait_idle();

      // Override Q to 1 across a reset command: mismatch, then sticky error
      ovr     = 1'b1;
      ovr_val = 1'b1;
      push(2'd1, 1);
      wait_idle();
      ovr = 1'b0;
      check("err_sticky", int'(err), 1);
      push(2'd2, 0);
      push(2'd3, 1);
      wait_idle();

      // Asynchronous reset in the middle of a toggle drive
      push(2'd3, 7);
      wait_busy();
      push(2'd2, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midreset_state", int'({J, K, busy, done, err, fifo_count, cmd_ready}), 1);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      push(2'd3, 0);
      wait_idle();

      // Longest hold
      push(2'd0, 15);
      wait_idle();

      // Randomised traffic with random gaps
      for (int i = 0; i < 40; i++) begin
         push(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      check("scoreboard_empty", exp_q.size(), 0);
      check("final_err", int'(err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
